saddc_block_feeder: RTL and testbench
=====================================

// Module: saddc_block_feeder
// PURPOSE
// - Producer/collector for ControlUnit. Takes a byte stream, assembles one 32-bit feature block and one 32-bit weight block, and drives them onto io_fBlock/io_wBlock.
// - Samples the returned io_decision and presents it downstream through a ready/valid port.
// - Sits between the byte-wide host/DMA link and the combinational ControlUnit decision tree.
// PARAMETERS
// - BLOCK_W  32  width of fBlock/wBlock; must be a multiple of BYTE_W
// - BYTE_W   8   input stream width
// - DEC_LAT  0   extra cycles to wait after committing blocks before sampling io_decision (0..15)
// - CNT_W    16  width of the processed-block counter
// PORTS
// - clk              in   1        single clock, rising edge
// - reset_n          in   1        asynchronous, active-low reset
// - io_in_valid      in   1        input byte valid
// - io_in_ready      out  1        feeder accepts a byte
// - io_in_data       in   BYTE_W   stream byte; order per block pair: fBlock MSB..LSB, then wBlock MSB..LSB
// - io_abort         in   1        synchronous flush of the block in progress
// - io_fBlock        out  BLOCK_W  committed feature block to ControlUnit
// - io_wBlock        out  BLOCK_W  committed weight block to ControlUnit
// - io_decision      in   1        ControlUnit result for the current io_fBlock/io_wBlock
// - io_out_valid     out  1        decision result valid
// - io_out_ready     in   1        downstream accepts the result
// - io_out_decision  out  1        sampled decision
// - io_blk_count     out  CNT_W    number of results accepted downstream since reset
// BEHAVIOUR
// - Reset values (async, on reset_n=0): state=LOAD_F; all of the following are 0:
//   - byte counter, staging regs, io_fBlock, io_wBlock
//   - io_out_valid, io_out_decision, io_blk_count
//   - io_in_ready, which goes to 1 on the first clock after reset release.
// - NB = BLOCK_W/BYTE_W bytes per block. Byte counter runs 0..NB-1 and clears on the last byte.
// - FSM states: LOAD_F, LOAD_W, SETTLE, EMIT.
// - LOAD_F:
//   - io_in_ready=1. Each accepted byte (in_valid & in_ready) does f_stg <= {f_stg, data}, truncated to BLOCK_W.
//   - After the NB-th byte, go to LOAD_W.
// - LOAD_W:
//   - io_in_ready=1. Same shifting into w_stg.
//   - On the NB-th byte, in the same edge: io_fBlock<=f_stg, io_wBlock<={w_stg, data}, settle_cnt<=DEC_LAT, go to SETTLE.
// - io_fBlock/io_wBlock change only at that commit edge. They never show partial data and hold through SETTLE and EMIT until the next commit.
// - SETTLE:
//   - io_in_ready=0.
//   - If settle_cnt==0: io_out_decision<=io_decision, io_out_valid<=1, go to EMIT.
//   - Otherwise settle_cnt decrements.
//   - SETTLE lasts DEC_LAT+1 cycles. With DEC_LAT=0, io_out_valid rises 2 edges after the last input byte.
// - EMIT:
//   - io_in_ready=0. io_out_valid and io_out_decision are held stable until io_out_ready=1.
//   - On the handshake edge: io_out_valid<=0, io_blk_count<=io_blk_count+1 (wraps modulo 2^CNT_W), go to LOAD_F.
// - No overlap: the next block pair's bytes are accepted starting the cycle after the EMIT handshake. Throughput is 2*NB+DEC_LAT+2 cycles per result minimum.
// - io_abort=1 (any state):
//   - Next edge: state=LOAD_F, byte counter=0, staging regs=0, io_out_valid=0.
//   - io_fBlock, io_wBlock, io_out_decision and io_blk_count keep their values.
//   - A byte presented in the abort cycle is not accepted: io_in_ready=0 while io_abort=1.
//   - Abort has priority over an out handshake in the same cycle; the count does not increment.
// - io_in_valid is ignored while io_in_ready=0. io_in_data is don't-care when io_in_valid=0.
// - Stalls: in_valid low mid-block holds the byte counter and staging regs indefinitely. out_ready low holds EMIT indefinitely.
// - Reset asserted mid-block or in EMIT: immediate return to reset values. The pending result is lost.
// TESTING
// - Bench models ControlUnit: decision = (sum|f_byte-w_byte| < 16).
// - T1 Basic: reset, then stream 11 22 33 44 / 11 22 33 45, out_ready=1, DEC_LAT=0.
//   - Required: io_fBlock=0x11223344, io_wBlock=0x11223345, io_out_decision=1.
//   - Required: io_out_valid=1 exactly 2 cycles after the last byte; io_blk_count=1.
// - T2 Backpressure and bubbles: random in_valid gaps; out_ready held low 10 cycles; pair 00000000/FF000000.
//   - Required: decision=0 held stable 10 cycles; in_ready=0 throughout EMIT; count increments once.
// - T3 Latency: DEC_LAT=3.
//   - Required: out_valid asserts 5 edges after the last byte.
//   - Required: changing io_decision before the sample edge has no effect once the result is captured.
// - T4 Abort: abort after 6 bytes, then a full fresh pair AABBCCDD/AABBCCDD.
//   - Required: no out_valid for the aborted pair; next result decision=1; count +1 only.
// - T5 Reset mid-operation: drop reset_n in SETTLE.
//   - Required: all outputs 0 asynchronously (before the next clock edge); in_ready=1 on the first clock after release.
// - T6 Wrap: preload 65535 results (or CNT_W=4 with 15 results), then one more.
//   - Required: io_blk_count wraps to 0; back-to-back pairs with no gaps yield one result per 10 cycles.

Source files
------------

// File: rtl/saddc_block_feeder_if.sv
// Bundle of the byte-stream input, the block pair going to ControlUnit and the
// decision result port of saddc_block_feeder.
interface saddc_block_feeder_if #(
    parameter int BLOCK_W = 32,
    parameter int BYTE_W  = 8,
    parameter int CNT_W   = 16
);
    logic               io_in_valid;
    logic               io_in_ready;
    logic [BYTE_W-1:0]  io_in_data;
    logic               io_abort;
    logic [BLOCK_W-1:0] io_fBlock;
    logic [BLOCK_W-1:0] io_wBlock;
    logic               io_decision;
    logic               io_out_valid;
    logic               io_out_ready;
    logic               io_out_decision;
    logic [CNT_W-1:0]   io_blk_count;

    modport master (
        output io_in_valid, io_in_data, io_abort, io_decision, io_out_ready,
        input  io_in_ready, io_fBlock, io_wBlock, io_out_valid, io_out_decision, io_blk_count
    );

    modport slave (
        input  io_in_valid, io_in_data, io_abort, io_decision, io_out_ready,
        output io_in_ready, io_fBlock, io_wBlock, io_out_valid, io_out_decision, io_blk_count
    );
endinterface

// File: rtl/saddc_block_feeder.sv
// Assembles a feature/weight block pair from a byte stream, presents it to
// ControlUnit and hands the sampled decision downstream over ready/valid.
module saddc_block_feeder #(
    parameter int BLOCK_W = 32,
    parameter int BYTE_W  = 8,
    parameter int DEC_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    saddc_block_feeder_if.slave bus
);
    localparam int NB   = BLOCK_W / BYTE_W;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);

    typedef enum logic [1:0] {LOAD_F, LOAD_W, SETTLE, EMIT} state_t;

    state_t             state;
    state_t             next_state;
    logic               ready_en;
    logic [BC_W-1:0]    byte_cnt;
    logic [BLOCK_W-1:0] f_stg;
    logic [BLOCK_W-1:0] w_stg;
    logic [BLOCK_W-1:0] f_block;
    logic [BLOCK_W-1:0] w_block;
    logic [3:0]         settle_cnt;
    logic               out_valid;
    logic               out_decision;
    logic [CNT_W-1:0]   blk_count;
    logic               in_ready;
    logic               accept;
    logic               last_byte;

    // ready_en keeps in_ready low until the first clock after reset release
    assign in_ready  = ready_en && !bus.io_abort && (state == LOAD_F || state == LOAD_W);
    assign accept    = bus.io_in_valid && in_ready;
    assign last_byte = (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD_F;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.io_abort) begin
            next_state = LOAD_F;
        end else begin
            case (state)
                LOAD_F:  if (accept && last_byte) next_state = LOAD_W;
                LOAD_W:  if (accept && last_byte) next_state = SETTLE;
                SETTLE:  if (settle_cnt == 4'd0) next_state = EMIT;
                EMIT:    if (bus.io_out_ready) next_state = LOAD_F;
                default: next_state = LOAD_F;
            endcase
        end
    end

    // Abort flushes the pair in progress but leaves committed blocks and the count alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en     <= 1'b0;
            byte_cnt     <= '0;
            f_stg        <= '0;
            w_stg        <= '0;
            f_block      <= '0;
            w_block      <= '0;
            settle_cnt   <= '0;
            out_valid    <= 1'b0;
            out_decision <= 1'b0;
            blk_count    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (bus.io_abort) begin
                byte_cnt  <= '0;
                f_stg     <= '0;
                w_stg     <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    LOAD_F: begin
                        if (accept) begin
                            f_stg    <= BLOCK_W'({f_stg, bus.io_in_data});
                            byte_cnt <= last_byte ? '0 : byte_cnt + BC_W'(1);
                        end
                    end
                    LOAD_W: begin
                        if (accept) begin
                            w_stg    <= BLOCK_W'({w_stg, bus.io_in_data});
                            byte_cnt <= last_byte ? '0 : byte_cnt + BC_W'(1);
                            if (last_byte) begin
                                f_block    <= f_stg;
                                w_block    <= BLOCK_W'({w_stg, bus.io_in_data});
                                settle_cnt <= 4'(DEC_LAT);
                            end
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == 4'd0) begin
                            out_decision <= bus.io_decision;
                            out_valid    <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    EMIT: begin
                        if (bus.io_out_ready) begin
                            out_valid <= 1'b0;
                            blk_count <= blk_count + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.io_in_ready     = in_ready;
    assign bus.io_fBlock       = f_block;
    assign bus.io_wBlock       = w_block;
    assign bus.io_out_valid    = out_valid;
    assign bus.io_out_decision = out_decision;
    assign bus.io_blk_count    = blk_count;
endmodule

// File: tb/tb_saddc_block_feeder.sv
// Directed/randomized bench for saddc_block_feeder: one instance with DEC_LAT=0
// and a 4-bit counter, one with DEC_LAT=3, checked against a byte-level model.
module tb_saddc_block_feeder;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       abort;
    logic       out_ready;
    logic       force_en;
    logic       force_val;

    int  vectors     = 0;
    int  miscompares = 0;
    int  exp_cnt;
    int  lat;
    int  n;
    time last_accept;
    time t0;
    time prev_t;
    logic [63:0] pair;
    logic [63:0] prev_pair;

    always #5 clk = ~clk;

    saddc_block_feeder_if #(.BLOCK_W(32), .BYTE_W(8), .CNT_W(4))  bus0 ();
    saddc_block_feeder_if #(.BLOCK_W(32), .BYTE_W(8), .CNT_W(16)) bus3 ();

    saddc_block_feeder #(.BLOCK_W(32), .BYTE_W(8), .DEC_LAT(0), .CNT_W(4)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    saddc_block_feeder #(.BLOCK_W(32), .BYTE_W(8), .DEC_LAT(3), .CNT_W(16)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    // ControlUnit stand-in: sum of absolute byte differences below 16
    function automatic logic cu_model(input logic [31:0] f, input logic [31:0] w);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            int a = int'(f[8*i +: 8]);
            int b = int'(w[8*i +: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return (s < 16);
    endfunction

    function automatic logic refDecision(input logic [63:0] p);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            int a = int'(p[63 - 8*i -: 8]);
            int b = int'(p[31 - 8*i -: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return (s < 16);
    endfunction

    function automatic logic [63:0] closePair(input logic [31:0] f);
        return {f, f ^ 32'h01020301};
    endfunction

    assign bus0.io_in_valid  = in_valid & ~sel;
    assign bus0.io_in_data   = in_data;
    assign bus0.io_abort     = abort & ~sel;
    assign bus0.io_out_ready = out_ready & ~sel;
    assign bus0.io_decision  = force_en ? force_val : cu_model(bus0.io_fBlock, bus0.io_wBlock);
    assign bus3.io_in_valid  = in_valid & sel;
    assign bus3.io_in_data   = in_data;
    assign bus3.io_abort     = abort & sel;
    assign bus3.io_out_ready = out_ready & sel;
    assign bus3.io_decision  = force_en ? force_val : cu_model(bus3.io_fBlock, bus3.io_wBlock);

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic        obs_out_dec;
    logic [31:0] obs_f;
    logic [31:0] obs_w;
    logic [15:0] obs_cnt;

    assign obs_in_ready  = sel ? bus3.io_in_ready     : bus0.io_in_ready;
    assign obs_out_valid = sel ? bus3.io_out_valid    : bus0.io_out_valid;
    assign obs_out_dec   = sel ? bus3.io_out_decision : bus0.io_out_decision;
    assign obs_f         = sel ? bus3.io_fBlock       : bus0.io_fBlock;
    assign obs_w         = sel ? bus3.io_wBlock       : bus0.io_wBlock;
    assign obs_cnt       = sel ? bus3.io_blk_count    : 16'(bus0.io_blk_count);

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyByte(input logic [7:0] b, input int gap);
        int t = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!obs_in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t == 64) checkOutput("in_ready_timeout", 64'(obs_in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        last_accept = $time;
    endtask

    task automatic applyStimulus(input logic [63:0] p, input int max_gap, output time first_t);
        first_t = 0;
        for (int i = 0; i < 8; i++) begin
            applyByte(p[63 - 8*i -: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
            if (i == 0) first_t = last_accept;
        end
    endtask

    task automatic waitResult(output int edges);
        edges = 1;
        while (!obs_out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sel = 1'b0; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
        out_ready = 1'b0; force_en = 1'b0; force_val = 1'b0; reset_n = 1'b0;
        exp_cnt = 0;

        // reset state
        #3;
        checkOutput("rst_in_ready",  64'(obs_in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(obs_out_valid), 64'd0);
        checkOutput("rst_out_dec",   64'(obs_out_dec), 64'd0);
        checkOutput("rst_fblock",    64'(obs_f), 64'd0);
        checkOutput("rst_wblock",    64'(obs_w), 64'd0);
        checkOutput("rst_count",     64'(obs_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("release_in_ready", 64'(obs_in_ready), 64'd0);
        @(posedge clk);
        #1 checkOutput("first_clk_in_ready", 64'(obs_in_ready), 64'd1);

        // T1 basic
        $display("[TB] T1 basic pair");
        out_ready = 1'b1;
        pair = 64'h11223344_11223345;
        applyStimulus(pair, 0, t0);
        waitResult(lat);
        checkOutput("t1_latency", 64'(lat), 64'd2);
        checkOutput("t1_fblock", 64'(obs_f), 64'(pair[63:32]));
        checkOutput("t1_wblock", 64'(obs_w), 64'(pair[31:0]));
        checkOutput("t1_dec", 64'(obs_out_dec), 64'(refDecision(pair)));
        @(posedge clk);
        #1;
        exp_cnt = (exp_cnt + 1) % 16;
        checkOutput("t1_count", 64'(obs_cnt), 64'(exp_cnt));
        checkOutput("t1_valid_drop", 64'(obs_out_valid), 64'd0);

        // T2 bubbles and backpressure
        $display("[TB] T2 backpressure");
        out_ready = 1'b0;
        pair = 64'h00000000_FF000000;
        applyStimulus(pair, 3, t0);
        waitResult(lat);
        checkOutput("t2_fblock", 64'(obs_f), 64'(pair[63:32]));
        checkOutput("t2_wblock", 64'(obs_w), 64'(pair[31:0]));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            checkOutput("t2_hold_valid", 64'(obs_out_valid), 64'd1);
            checkOutput("t2_hold_dec", 64'(obs_out_dec), 64'(refDecision(pair)));
            checkOutput("t2_in_ready_emit", 64'(obs_in_ready), 64'd0);
        end
        checkOutput("t2_count_hold", 64'(obs_cnt), 64'(exp_cnt));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = (exp_cnt + 1) % 16;
        checkOutput("t2_count", 64'(obs_cnt), 64'(exp_cnt));
        checkOutput("t2_valid_drop", 64'(obs_out_valid), 64'd0);
        checkOutput("t2_fblock_kept", 64'(obs_f), 64'(pair[63:32]));
        prev_pair = pair;

        // T4 abort mid-pair, then a fresh pair
        $display("[TB] T4 abort");
        pair = {$urandom(), $urandom()};
        for (int i = 0; i < 6; i++) applyByte(pair[63 - 8*i -: 8], 0);
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        #1 checkOutput("t4_in_ready_abort", 64'(obs_in_ready), 64'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("t4_no_valid", 64'(obs_out_valid), 64'd0);
        checkOutput("t4_fblock_kept", 64'(obs_f), 64'(prev_pair[63:32]));
        checkOutput("t4_wblock_kept", 64'(obs_w), 64'(prev_pair[31:0]));
        checkOutput("t4_count_kept", 64'(obs_cnt), 64'(exp_cnt));
        pair = 64'hAABBCCDD_AABBCCDD;
        applyStimulus(pair, 1, t0);
        waitResult(lat);
        checkOutput("t4_latency", 64'(lat), 64'd2);
        checkOutput("t4_fblock", 64'(obs_f), 64'(pair[63:32]));
        checkOutput("t4_wblock", 64'(obs_w), 64'(pair[31:0]));
        checkOutput("t4_dec", 64'(obs_out_dec), 64'(refDecision(pair)));
        @(posedge clk);
        #1;
        exp_cnt = (exp_cnt + 1) % 16;
        checkOutput("t4_count", 64'(obs_cnt), 64'(exp_cnt));

        // abort beats an out handshake in the same cycle
        out_ready = 1'b0;
        pair = closePair($urandom());
        applyStimulus(pair, 0, t0);
        waitResult(lat);
        checkOutput("t4b_valid", 64'(obs_out_valid), 64'd1);
        @(negedge clk);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        checkOutput("t4b_valid_cleared", 64'(obs_out_valid), 64'd0);
        checkOutput("t4b_count_kept", 64'(obs_cnt), 64'(exp_cnt));
        checkOutput("t4b_fblock_kept", 64'(obs_f), 64'(pair[63:32]));
        checkOutput("t4b_dec_kept", 64'(obs_out_dec), 64'(refDecision(pair)));

        // T6 back-to-back random pairs until the 4-bit count wraps
        $display("[TB] T6 wrap and throughput");
        n = 0;
        prev_t = 0;
        do begin
            pair = (n % 2 == 1) ? closePair($urandom()) : {$urandom(), $urandom()};
            applyStimulus(pair, 0, t0);
            waitResult(lat);
            checkOutput("t6_latency", 64'(lat), 64'd2);
            checkOutput("t6_fblock", 64'(obs_f), 64'(pair[63:32]));
            checkOutput("t6_wblock", 64'(obs_w), 64'(pair[31:0]));
            checkOutput("t6_dec", 64'(obs_out_dec), 64'(refDecision(pair)));
            checkOutput("t6_count", 64'(obs_cnt), 64'(exp_cnt));
            if (n > 0) checkOutput("t6_spacing", 64'((t0 - prev_t) / 10), 64'd10);
            prev_t  = t0;
            exp_cnt = (exp_cnt + 1) % 16;
            n++;
        end while (exp_cnt != 0 && n < 20);
        @(posedge clk);
        #1 checkOutput("t6_wrap", 64'(obs_cnt), 64'd0);

        // T3 DEC_LAT=3 instance
        $display("[TB] T3 decision latency");
        @(negedge clk);
        sel       = 1'b1;
        out_ready = 1'b0;
        exp_cnt   = 0;
        #1;
        checkOutput("t3_idle_count", 64'(obs_cnt), 64'd0);
        checkOutput("t3_idle_ready", 64'(obs_in_ready), 64'd1);
        pair = closePair($urandom());
        applyStimulus(pair, 0, t0);
        force_val = ~refDecision(pair);
        force_en  = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk);
            #1 checkOutput("t3_settle_no_valid", 64'(obs_out_valid), 64'd0);
        end
        @(negedge clk);
        force_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t3_valid_edge5", 64'(obs_out_valid), 64'd1);
        checkOutput("t3_dec", 64'(obs_out_dec), 64'(refDecision(pair)));
        force_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 checkOutput("t3_dec_held", 64'(obs_out_dec), 64'(refDecision(pair)));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        force_en = 1'b0;
        exp_cnt  = exp_cnt + 1;
        checkOutput("t3_count", 64'(obs_cnt), 64'(exp_cnt));
        checkOutput("t3_valid_drop", 64'(obs_out_valid), 64'd0);

        // T5 reset while in SETTLE
        $display("[TB] T5 reset mid-operation");
        pair = {$urandom(), $urandom()} | 64'h01000000_01000000;
        applyStimulus(pair, 0, t0);
        @(posedge clk);
        #1 checkOutput("t5_committed", 64'(obs_f), 64'(pair[63:32]));
        #1 reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 64'(obs_out_valid), 64'd0);
        checkOutput("t5_rst_fblock", 64'(obs_f), 64'd0);
        checkOutput("t5_rst_wblock", 64'(obs_w), 64'd0);
        checkOutput("t5_rst_dec", 64'(obs_out_dec), 64'd0);
        checkOutput("t5_rst_count", 64'(obs_cnt), 64'd0);
        checkOutput("t5_rst_in_ready", 64'(obs_in_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("t5_release_ready", 64'(obs_in_ready), 64'd0);
        @(posedge clk);
        #1 checkOutput("t5_first_clk_ready", 64'(obs_in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
